// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: serializes one DATA_W word per handshake, MSB first, and captures MISO.
// Optional echo checking of the previous frame's word is enabled by SPI_MASTER_ECHO_CHK_EN.
module spi_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              echo_err,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, DONE, GAP} state_t;

    state_t            state;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [7:0]        div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              div_end;

`ifdef SPI_MASTER_ECHO_CHK_EN
    logic [DATA_W-1:0] cur_tx;
    logic [DATA_W-1:0] prev_tx;
    logic              have_prev;
`else
    assign echo_err = 1'b0;
`endif

    assign div_end = (div_cnt == DIV_LAST);

    // All outputs are registered and updated on the edge that enters the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
`ifdef SPI_MASTER_ECHO_CHK_EN
            cur_tx    <= '0;
            prev_tx   <= '0;
            have_prev <= 1'b0;
            echo_err  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        rx_shift <= '0;
                        mosi     <= tx_data[DATA_W-1];
                        ss_n     <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
`ifdef SPI_MASTER_ECHO_CHK_EN
                        cur_tx   <= tx_data;
`endif
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        sclk     <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        state    <= SCLK_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SCLK_HI: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        sclk     <= 1'b0;
                        tx_shift <= tx_shift << 1;
                        mosi     <= tx_shift[DATA_W-2];
                        state    <= SCLK_LO;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SCLK_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            ss_n     <= 1'b1;
                            mosi     <= 1'b0;
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            state    <= DONE;
`ifdef SPI_MASTER_ECHO_CHK_EN
                            // The slave echoes the previous frame, so frame one has nothing to compare.
                            if (have_prev && (rx_shift != prev_tx))
                                echo_err <= 1'b1;
                            prev_tx   <= cur_tx;
                            have_prev <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            sclk     <= 1'b1;
                            rx_shift <= {rx_shift[DATA_W-2:0], miso};
                            state    <= SCLK_HI;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    div_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt  <= '0;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: an 8-bit default instance and a 16-bit CLK_DIV=1 instance,
// each driven against a mode-0 slave model and a frame-level reference model.
module tb_spi_master_ctrl;

`ifdef SPI_MASTER_ECHO_CHK_EN
    localparam bit ECHO_ON = 1'b1;
`else
    localparam bit ECHO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        tx_valid0 = 1'b0, tx_ready0, rx_valid0, busy0, echo_err0, sclk0, mosi0, miso0, ss_n0;
    logic [7:0]  tx_data0 = '0, rx_data0;
    logic        tx_valid1 = 1'b0, tx_ready1, rx_valid1, busy1, echo_err1, sclk1, mosi1, miso1, ss_n1;
    logic [15:0] tx_data1 = '0, rx_data1;

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4), .GAP_CYC(4)) dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
        .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0), .echo_err(echo_err0),
        .sclk(sclk0), .mosi(mosi0), .miso(miso0), .ss_n(ss_n0));

    spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1), .GAP_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
        .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1), .echo_err(echo_err1),
        .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss_n(ss_n1));

    // Mode-0 slaves: load on ss_n fall, shift on SCLK fall, capture MOSI on SCLK rise.
    logic [7:0]  sl_word0 = '0, sl_sh0 = '0, mcap0 = '0;
    logic [15:0] sl_word1 = '0, sl_sh1 = '0, mcap1 = '0;
    logic        armed0 = 1'b0, armed1 = 1'b0;
    int          pcnt0 = 0, pcnt1 = 0;
    assign miso0 = sl_sh0[7];
    assign miso1 = sl_sh1[15];

    always @(negedge ss_n0 or posedge ss_n0 or negedge sclk0) begin
        if (ss_n0) armed0 = 1'b0;
        else if (!armed0) begin sl_sh0 = sl_word0; armed0 = 1'b1; end
        else sl_sh0 = {sl_sh0[6:0], 1'b0};
    end
    always @(negedge ss_n1 or posedge ss_n1 or negedge sclk1) begin
        if (ss_n1) armed1 = 1'b0;
        else if (!armed1) begin sl_sh1 = sl_word1; armed1 = 1'b1; end
        else sl_sh1 = {sl_sh1[14:0], 1'b0};
    end
    always @(posedge sclk0 or negedge ss_n0) begin
        if (sclk0) begin mcap0 = {mcap0[6:0], mosi0}; pcnt0++; end
        else begin mcap0 = '0; pcnt0 = 0; end
    end
    always @(posedge sclk1 or negedge ss_n1) begin
        if (sclk1) begin mcap1 = {mcap1[14:0], mosi1}; pcnt1++; end
        else begin mcap1 = '0; pcnt1 = 0; end
    end

    int checks = 0;
    int errors = 0;

    // Frame-level echo model: sticky error once a received word differs from the previous sent word.
    logic        m_err [2];
    logic        m_ok  [2];
    logic [15:0] m_prev[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin m_err[i] = 1'b0; m_ok[i] = 1'b0; m_prev[i] = '0; end
    endtask

    task automatic model_done(input int sel, input logic [15:0] tx, input logic [15:0] rx);
        if (ECHO_ON && m_ok[sel] && (rx != m_prev[sel])) m_err[sel] = 1'b1;
        m_prev[sel] = tx;
        m_ok[sel]   = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);  return sel ? tx_ready1 : tx_ready0; endfunction
    function automatic logic rxv(input int sel);  return sel ? rx_valid1 : rx_valid0; endfunction
    function automatic logic ssn(input int sel);  return sel ? ss_n1 : ss_n0; endfunction
    function automatic logic eerr(input int sel); return sel ? echo_err1 : echo_err0; endfunction
    function automatic logic [15:0] rxd(input int sel);  return sel ? rx_data1 : {8'h00, rx_data0}; endfunction
    function automatic logic [15:0] mcap(input int sel); return sel ? mcap1 : {8'h00, mcap0}; endfunction
    function automatic int pcnt(input int sel); return sel ? pcnt1 : pcnt0; endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] d);
        if (sel != 0) begin tx_valid1 = v; tx_data1 = d; end
        else begin tx_valid0 = v; tx_data0 = d[7:0]; end
    endtask

    // One complete frame; expected timing comes from the frame-length formulas.
    task automatic run_frame(input int sel, input logic [15:0] tx, input logic [15:0] sl);
        int W  = sel ? 16 : 8;
        int CD = sel ? 1 : 4;
        int GP = sel ? 2 : 4;
        logic [15:0] mask = sel ? 16'hFFFF : 16'h00FF;
        int c = 0;
        @(negedge clk);
        while (!rdy(sel) && c < 500) begin @(negedge clk); c++; end
        chk("ready_wait", {31'b0, rdy(sel)}, 1);
        if (sel != 0) sl_word1 = sl; else sl_word0 = sl[7:0];
        drive(sel, 1'b1, tx);
        @(posedge clk); #1;
        drive(sel, 1'b0, tx);
        c = 1;
        chk("ss_n_fall", {31'b0, ssn(sel)}, 0);
        while (!rxv(sel) && c < 2000) begin @(posedge clk); #1; c++; end
        chk("rx_valid_cycle", c, 1 + CD + 2 * W * CD);
        model_done(sel, tx & mask, sl & mask);
        chk("rx_data", rxd(sel), sl & mask);
        chk("mosi_bits", mcap(sel), tx & mask);
        chk("sclk_pulses", pcnt(sel), W);
        chk("ss_n_done", {31'b0, ssn(sel)}, 1);
        chk("echo_err", {31'b0, eerr(sel)}, {31'b0, m_err[sel]});
        @(posedge clk); #1; c++;
        chk("rx_valid_pulse", {31'b0, rxv(sel)}, 0);
        chk("rx_data_hold", rxd(sel), sl & mask);
        while (!rdy(sel) && c < 3000) begin @(posedge clk); #1; c++; end
        chk("ready_cycle", c, 2 + CD + 2 * W * CD + GP);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] tx;
        logic [15:0] sl;
        logic [15:0] exp_rx;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int c, nrx, acc2, hi, rxc2;
        bit gap_done;
        tbl[0] = '{0, 16'h00A5, 16'h003C, 16'h003C};
        tbl[1] = '{0, 16'h00FF, 16'h0000, 16'h0000};
        tbl[2] = '{0, 16'h0000, 16'h00FF, 16'h00FF};
        tbl[3] = '{0, 16'h0080, 16'h0001, 16'h0001};
        tbl[4] = '{1, 16'hBEEF, 16'h1234, 16'h1234};
        tbl[5] = '{1, 16'h0001, 16'h8000, 16'h8000};
        model_reset();

        // Reset values
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", {31'b0, tx_ready0}, 0);
        chk("rst_ss_n", {31'b0, ss_n0}, 1);
        chk("rst_sclk", {31'b0, sclk0}, 0);
        chk("rst_mosi", {31'b0, mosi0}, 0);
        chk("rst_rx_valid", {31'b0, rx_valid0}, 0);
        chk("rst_rx_data", {24'b0, rx_data0}, 0);
        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_echo_err", {31'b0, echo_err0}, 0);
        chk("rst_ss_n_w16", {31'b0, ss_n1}, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("tx_ready_after_rst", {31'b0, tx_ready0}, 1);
        chk("tx_ready_after_rst_w16", {31'b0, tx_ready1}, 1);

        // Echo sequence: first frame after reset is exempt
        run_frame(0, 16'h11, 16'h00);
        run_frame(0, 16'h22, 16'h11);
        run_frame(0, 16'h33, 16'h77);

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].sel, tbl[i].tx, tbl[i].sl);
            chk("tbl_rx", rxd(tbl[i].sel), tbl[i].exp_rx);
        end

        for (int i = 0; i < 8; i++)
            run_frame(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++)
            run_frame(1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));

        // Back-to-back with tx_valid held
        @(negedge clk);
        sl_word0 = 8'h5A;
        tx_valid0 = 1'b1; tx_data0 = 8'h01;
        @(posedge clk); #1;
        tx_data0 = 8'h02;
        c = 1; nrx = 0; acc2 = 0; hi = 0; rxc2 = 0; gap_done = 1'b0;
        while (c < 400 && nrx < 2) begin
            if (rx_valid0) begin
                nrx++;
                model_done(0, (nrx == 1) ? 16'h01 : 16'h02, 16'h5A);
                chk("b2b_rx_data", {24'b0, rx_data0}, 32'h5A);
                chk("b2b_mosi", {24'b0, mcap0}, (nrx == 1) ? 32'h01 : 32'h02);
                chk("b2b_echo_err", {31'b0, echo_err0}, {31'b0, m_err[0]});
                if (nrx == 2) rxc2 = c;
            end
            if (tx_ready0 && acc2 == 0) acc2 = c;
            if (acc2 != 0 && c == acc2 + 1) tx_valid0 = 1'b0;
            if (nrx == 1 && !gap_done) begin
                if (ss_n0) hi++; else gap_done = 1'b1;
            end
            @(posedge clk); #1; c++;
        end
        tx_valid0 = 1'b0;
        chk("b2b_second_accept", acc2, 74);
        chk("b2b_rx_count", nrx, 2);
        chk("b2b_second_rx_cycle", rxc2, 74 + 69);
        chk("b2b_gap_min", {31'b0, (hi >= 5)}, 1);

        // Mid-frame reset
        @(negedge clk);
        sl_word0 = 8'hC3;
        tx_valid0 = 1'b1; tx_data0 = 8'h96;
        @(posedge clk); #1;
        tx_valid0 = 1'b0;
        repeat (29) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("abort_ss_n", {31'b0, ss_n0}, 1);
        chk("abort_sclk", {31'b0, sclk0}, 0);
        nrx = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rx_valid0) nrx++;
        end
        chk("abort_no_rx_valid", nrx, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'b0, tx_ready0}, 1);
        run_frame(0, 16'h96, 16'hC3);
        run_frame(0, 16'h4B, 16'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
